// File: rtl/types_pkg.sv
// Shared types for the pipeline: memory-control bits, stage-three FSM states
// and the write-back bundle consumed by fetch/decode.
package types_pkg;

  typedef struct packed {
    logic mem2r;
    logic memwr;
  } memc_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic        reg_wr;
    logic        R0_en;
    logic [31:0] data;
    logic [7:0]  instr;
  } s3_bundle_t;

  // A memory op is rejected when both directions are requested or the word address is odd.
  function automatic logic memc_illegal(input memc_t memc, input logic [15:0] addr);
    return (memc.mem2r & memc.memwr) | ((memc.mem2r | memc.memwr) & addr[0]);
  endfunction

endpackage

// File: rtl/dmem_timeout_counter.sv
// Wait-cycle counter for an outstanding data-memory access; tc_o flags the
// last permitted cycle before the access is abandoned.
module dmem_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/stage_mem_wb.sv
// Pipeline stage three: performs data-memory loads/stores over a req/ack
// handshake and presents the registered write-back bundle to fetch/decode.
module stage_mem_wb
  import types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        in_valid,
  input  memc_t       in_memc,
  input  logic        in_reg_wr,
  input  logic        in_R0_en,
  input  logic [31:0] in_alu_out,
  input  logic [15:0] in_store_data,
  input  logic [7:0]  in_instr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        mem_busy,
  output logic        s3_valid,
  output logic        s3_reg_wr,
  output logic        s3_R0_en,
  output logic [31:0] s3_data,
  output logic [7:0]  s3_instruction,
  output logic        mem_err
);

  wb_state_e  state_q, state_d;
  logic       req_q, req_d;
  logic       we_q, we_d;
  logic       load_q, load_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  s3_bundle_t wb_q, wb_d;

  logic advance, accept, is_mem, bad_op, start, ack_evt, timeout, cnt_tc;

  // Halt freezes every event; an ack seen while halted is simply not consumed.
  assign advance = !halt_sys;
  assign accept  = advance && (state_q == IDLE) && in_valid;
  assign is_mem  = in_memc.mem2r | in_memc.memwr;
  assign bad_op  = memc_illegal(in_memc, in_alu_out[15:0]);
  assign start   = accept && is_mem && !bad_op;
  assign ack_evt = advance && (state_q == ACCESS) && dmem_ack;
  assign timeout = advance && (state_q == ACCESS) && !dmem_ack && cnt_tc;

  dmem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load_i (start),
    .en_i   (advance && (state_q == ACCESS)),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  if (ack_evt || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    load_d  = load_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    err_d   = err_q;
    wb_d    = wb_q;

    if (advance) begin
      // Flags are qualified by valid; data and instruction hold between pulses.
      valid_d      = 1'b0;
      wb_d.reg_wr  = 1'b0;
      wb_d.R0_en   = 1'b0;

      if (accept) begin
        wb_d.instr = in_instr;
        if (!is_mem) begin
          valid_d     = 1'b1;
          wb_d.reg_wr = in_reg_wr;
          wb_d.R0_en  = in_R0_en;
          wb_d.data   = in_alu_out;
        end else if (bad_op) begin
          valid_d   = 1'b1;
          err_d     = 1'b1;
          wb_d.data = {16'h0000, in_alu_out[15:0]};
        end else begin
          req_d   = 1'b1;
          we_d    = in_memc.memwr;
          load_d  = in_memc.mem2r;
          addr_d  = in_alu_out[15:0];
          wdata_d = in_store_data;
        end
      end else if (ack_evt) begin
        req_d   = 1'b0;
        valid_d = 1'b1;
        if (load_q) begin
          wb_d.data   = {16'h0000, dmem_rdata};
          wb_d.reg_wr = 1'b1;
        end else begin
          wb_d.data = {16'h0000, addr_q};
        end
      end else if (timeout) begin
        req_d   = 1'b0;
        valid_d = 1'b1;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wb_q    <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wb_q    <= wb_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign mem_busy       = (state_q == ACCESS);
  assign s3_valid       = valid_q;
  assign s3_reg_wr      = wb_q.reg_wr;
  assign s3_R0_en       = wb_q.R0_en;
  assign s3_data        = wb_q.data;
  assign s3_instruction = wb_q.instr;
  assign mem_err        = err_q;

endmodule

// File: tb/tb_stage_mem_wb.sv
// Directed bench for stage_mem_wb: ALU pass-through, load/store handshakes,
// timeout, illegal ops, halt and mid-access reset.
module tb_stage_mem_wb;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        rst, halt_sys, in_valid, in_reg_wr, in_R0_en;
  memc_t       in_memc;
  logic [31:0] in_alu_out;
  logic [15:0] in_store_data;
  logic [7:0]  in_instr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_busy, s3_valid, s3_reg_wr, s3_R0_en, mem_err;
  logic [31:0] s3_data;
  logic [7:0]  s3_instruction;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stage_mem_wb #(.TIMEOUT(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .halt_sys       (halt_sys),
    .in_valid       (in_valid),
    .in_memc        (in_memc),
    .in_reg_wr      (in_reg_wr),
    .in_R0_en       (in_R0_en),
    .in_alu_out     (in_alu_out),
    .in_store_data  (in_store_data),
    .in_instr       (in_instr),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .mem_busy       (mem_busy),
    .s3_valid       (s3_valid),
    .s3_reg_wr      (s3_reg_wr),
    .s3_R0_en       (s3_R0_en),
    .s3_data        (s3_data),
    .s3_instruction (s3_instruction),
    .mem_err        (mem_err)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic mem2r, input logic memwr, input logic reg_wr,
                          input logic r0, input logic [31:0] alu, input logic [15:0] sd,
                          input logic [7:0] instr);
    in_valid      = 1'b1;
    in_memc.mem2r = mem2r;
    in_memc.memwr = memwr;
    in_reg_wr     = reg_wr;
    in_R0_en      = r0;
    in_alu_out    = alu;
    in_store_data = sd;
    in_instr      = instr;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  function automatic logic [91:0] all_outputs();
    return {dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_busy, s3_valid,
            s3_reg_wr, s3_R0_en, s3_data, s3_instruction, mem_err};
  endfunction

  task automatic test_reset();
    rst = 1'b0; halt_sys = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    drive_op(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    in_valid = 1'b0;
    step(); step();
    n_checks++;
    if (all_outputs() !== 92'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu();
    drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0005, 16'h0, 8'h10);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({s3_valid, s3_reg_wr, s3_data, mem_busy} !== {1'b1, 1'b1, 32'h5, 1'b0}) begin
      n_fail++; $display("FAIL alu_wb: valid=%b reg_wr=%b data=%h busy=%b expected 1 1 00000005 0",
                         s3_valid, s3_reg_wr, s3_data, mem_busy);
    end
    step();
    n_checks++;
    if ({s3_valid, s3_reg_wr, s3_data, mem_busy} !== {1'b0, 1'b0, 32'h5, 1'b0}) begin
      n_fail++; $display("FAIL alu_pulse_end: valid=%b reg_wr=%b data=%h busy=%b expected 0 0 00000005 0",
                         s3_valid, s3_reg_wr, s3_data, mem_busy);
    end
  endtask

  task automatic test_load();
    int busy_cycles = 0;
    int addr_bad = 0;
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 16'h0, 8'h51);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
      n_fail++; $display("FAIL load_req: req=%b we=%b addr=%h expected 1 0 0040", dmem_req, dmem_we, dmem_addr);
    end
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin dmem_ack = 1'b1; dmem_rdata = 16'hBEEF; end
      if (mem_busy) busy_cycles++;
      if (dmem_addr !== 16'h0040) addr_bad++;
      step();
      dmem_ack = 1'b0;
      if (s3_valid) break;
    end
    n_checks++;
    if (busy_cycles !== 4) begin
      n_fail++; $display("FAIL load_busy_cycles: got %0d expected 4", busy_cycles);
    end
    n_checks++;
    if (addr_bad !== 0) begin
      n_fail++; $display("FAIL load_addr_stable: %0d unstable cycles expected 0", addr_bad);
    end
    n_checks++;
    if ({s3_valid, s3_data, s3_reg_wr, s3_R0_en, s3_instruction, dmem_req, mem_busy} !==
        {1'b1, 32'h0000_BEEF, 1'b1, 1'b0, 8'h51, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL load_wb: valid=%b data=%h reg_wr=%b r0=%b instr=%h req=%b busy=%b expected 1 0000beef 1 0 51 0 0",
                         s3_valid, s3_data, s3_reg_wr, s3_R0_en, s3_instruction, dmem_req, mem_busy);
    end
    step();
  endtask

  task automatic test_store_back_to_back();
    drive_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 16'h1234, 8'h62);
    step();
    n_checks++;
    if ({dmem_req, dmem_we, dmem_wdata, dmem_addr} !== {1'b1, 1'b1, 16'h1234, 16'h0010}) begin
      n_fail++; $display("FAIL store_req: req=%b we=%b wdata=%h addr=%h expected 1 1 1234 0010",
                         dmem_req, dmem_we, dmem_wdata, dmem_addr);
    end
    // Offered while busy: must be ignored, then taken the cycle after ack.
    drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 16'h0, 8'h03);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    n_checks++;
    if ({s3_valid, s3_reg_wr, s3_R0_en, s3_data, dmem_req, mem_busy} !==
        {1'b1, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL store_wb: valid=%b reg_wr=%b r0=%b data=%h req=%b busy=%b expected 1 0 0 00000010 0 0",
                         s3_valid, s3_reg_wr, s3_R0_en, s3_data, dmem_req, mem_busy);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({s3_valid, s3_reg_wr, s3_data, s3_instruction} !== {1'b1, 1'b1, 32'h0000_0077, 8'h03}) begin
      n_fail++; $display("FAIL store_followup: valid=%b reg_wr=%b data=%h instr=%h expected 1 1 00000077 03",
                         s3_valid, s3_reg_wr, s3_data, s3_instruction);
    end
    step();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    n_checks++;
    if (mem_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear_before_timeout: got %b expected 0", mem_err);
    end
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 16'h0, 8'h44);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dmem_req) req_cycles++;
      if (s3_valid) break;
      step();
    end
    n_checks++;
    if (req_cycles !== 15) begin
      n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 15", req_cycles);
    end
    n_checks++;
    if ({s3_valid, s3_reg_wr, mem_err, dmem_req, mem_busy} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL timeout_wb: valid=%b reg_wr=%b err=%b req=%b busy=%b expected 1 0 1 0 0",
                         s3_valid, s3_reg_wr, mem_err, dmem_req, mem_busy);
    end
    step();
  endtask

  task automatic test_illegal();
    do_reset();
    drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0041, 16'h0, 8'h55);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({dmem_req, mem_busy, s3_valid, s3_reg_wr, s3_R0_en, mem_err} !== 6'b001001) begin
      n_fail++; $display("FAIL misaligned: req=%b busy=%b valid=%b reg_wr=%b r0=%b err=%b expected 0 0 1 0 0 1",
                         dmem_req, mem_busy, s3_valid, s3_reg_wr, s3_R0_en, mem_err);
    end
    step();
    do_reset();
    drive_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0050, 16'h0, 8'h56);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({dmem_req, mem_busy, s3_valid, s3_reg_wr, s3_R0_en, mem_err} !== 6'b001001) begin
      n_fail++; $display("FAIL both_bits: req=%b busy=%b valid=%b reg_wr=%b r0=%b err=%b expected 0 0 1 0 0 1",
                         dmem_req, mem_busy, s3_valid, s3_reg_wr, s3_R0_en, mem_err);
    end
    step();
  endtask

  task automatic test_halt_reset();
    int bad = 0;
    // A write-back pulse is stretched while halted.
    drive_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_2222, 16'h0, 8'h7E);
    step();
    in_valid = 1'b0;
    halt_sys = 1'b1;
    step(); step();
    n_checks++;
    if ({s3_valid, s3_reg_wr, s3_R0_en, s3_data} !== {1'b1, 1'b1, 1'b1, 32'h1111_2222}) begin
      n_fail++; $display("FAIL halt_extend: valid=%b reg_wr=%b r0=%b data=%h expected 1 1 1 11112222",
                         s3_valid, s3_reg_wr, s3_R0_en, s3_data);
    end
    halt_sys = 1'b0;
    step();
    n_checks++;
    if (s3_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_release_pulse: valid=%b expected 0", s3_valid);
    end
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 16'h5555, 8'h9A);
    step();
    in_valid = 1'b0;
    halt_sys = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 16'hAAAA;
    for (int c = 0; c < 5; c++) begin
      step();
      if ({dmem_addr, dmem_req, mem_busy, s3_valid} !== {16'h0080, 1'b1, 1'b1, 1'b0}) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL halt_hold: %0d bad cycles expected 0", bad);
    end
    halt_sys = 1'b0;
    dmem_ack = 1'b0;
    step();
    n_checks++;
    if ({mem_busy, dmem_req, s3_valid} !== 3'b110) begin
      n_fail++; $display("FAIL halt_ack_ignored: busy=%b req=%b valid=%b expected 1 1 0",
                         mem_busy, dmem_req, s3_valid);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (all_outputs() !== 92'd0) begin
      n_fail++; $display("FAIL midaccess_reset: got %h expected 0", all_outputs());
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({mem_busy, dmem_req, s3_valid} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_idle: busy=%b req=%b valid=%b expected 0 0 0",
                         mem_busy, dmem_req, s3_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_back_to_back();
    test_timeout();
    test_illegal();
    test_halt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation exceeded 100000 time units");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/stage_mem_wb.md
# stage_mem_wb

Pipeline stage three: the memory/write-back end of the datapath. It accepts the registered ALU result and control bits from stage two and performs any data-memory load or store through a req/ack handshake. It returns the write-back bundle (`s3_reg_wr`, `s3_R0_en`, `s3_data`, `s3_instruction`) that the fetch/decode stage consumes for register-file writes and forwarding. While a memory access is outstanding it stalls upstream.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum cycles to wait for `dmem_ack` before aborting (1..255).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `halt_sys` in 1: freeze. All state and outputs hold.
- `in_valid` in 1: stage-two bundle valid.
- `in_memc` in `memc_t`: {`mem2r`, `memwr`}.
- `in_reg_wr` in 1: write Rd.
- `in_R0_en` in 1: also write R0 from upper half.
- `in_alu_out` in 32: [15:0] result/address, [31:16] R0 result.
- `in_store_data` in 16: store value.
- `in_instr` in 8: {opcode, r1}.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 16, `dmem_wdata` out 16: data-memory request.
- `dmem_ack` in 1, `dmem_rdata` in 16: memory response, `dmem_rdata` valid with ack.
- `mem_busy` out 1: stall upstream. Stage two holds its bundle while high.
- `s3_valid` out 1: write-back bundle valid, one-cycle pulse.
- `s3_reg_wr` out 1, `s3_R0_en` out 1, `s3_data` out 32, `s3_instruction` out 8: write-back bundle.
- `mem_err` out 1: sticky; cleared only by reset.

## Operation
States:
- IDLE
- ACCESS

Behaviour by state and event:
- **IDLE, `in_valid`, `in_memc`=0:** latch the bundle. Next cycle:
  - `s3_valid`=1.
  - `s3_data`=`in_alu_out`.
  - `s3_reg_wr`=`in_reg_wr`.
  - `s3_R0_en`=`in_R0_en`.
  - Stay IDLE.
- **IDLE, `in_valid`, exactly one of `mem2r`/`memwr`:**
  - Latch address `in_alu_out[15:0]`, `in_store_data`, and the control bits. Go to ACCESS.
  - `dmem_req`=1 from the next cycle.
  - `dmem_addr`, `dmem_we` (=`memwr`), and `dmem_wdata` stay stable until ack.
- **ACCESS:**
  - `mem_busy`=1, `in_valid` ignored.
  - A cycle counter increments each unhalted cycle.
  - On `dmem_ack`: drop `dmem_req`, return to IDLE, and emit the bundle the next cycle.
    - Load: `s3_data`={16'h0000, `dmem_rdata`}, `s3_reg_wr`=1, `s3_R0_en`=0.
    - Store: `s3_reg_wr`=0, `s3_R0_en`=0, `s3_data`=latched address (zero-extended).
- **Timeout:** the counter reaches `TIMEOUT` without ack.
  - Drop the request, set `mem_err`, return to IDLE.
  - Emit `s3_valid`=1 with `s3_reg_wr`=0.
- **Illegal or misaligned (checked in IDLE):** `mem2r`&`memwr` both set, or word access with address[0]=1.
  - No request issued; set `mem_err`.
  - Emit `s3_valid`=1 with `s3_reg_wr`=0 and `s3_R0_en`=0 the next cycle.
- **Qualification:** `s3_reg_wr` and `s3_R0_en` are forced 0 whenever `s3_valid`=0. `s3_data` and `s3_instruction` hold their last value.
- **`halt_sys`=1:** nothing advances. `dmem_req` and the counter hold. A pulsing `s3_valid` is extended until halt drops. A `dmem_ack` arriving during halt is ignored, and memory must re-present it.

## Timing
- All outputs are registered. `mem_busy` = (state==ACCESS).
- Non-memory op: accepted at edge N, `s3_valid` high in cycle N+1 only.
- Load/store with zero-wait ack:
  - `dmem_req` high N+1.
  - ack sampled at edge N+2.
  - `s3_valid` N+2..N+3 (one cycle).
- Each wait cycle adds one cycle to the latency above.
- Throughput: one non-memory op per cycle; back-to-back memory ops have one IDLE cycle between requests.
- Reset values: `rst`=0 at an edge forces the following, including mid-access (the request is abandoned):
  - state=IDLE.
  - `dmem_req`=0, `dmem_we`=0.
  - `dmem_addr`=0, `dmem_wdata`=0.
  - `mem_busy`=0, `s3_valid`=0.
  - `s3_reg_wr`=0, `s3_R0_en`=0.
  - `s3_data`=0, `s3_instruction`=0.
  - `mem_err`=0.
  - counter=0.

## Structure
- `types_pkg`: add `wb_state_e` {IDLE, ACCESS} and the `s3_bundle_t` struct {reg_wr, R0_en, data[31:0], instr[7:0]}.
- `memc_t` is reused unchanged.
- One sub-module, `dmem_timeout_counter`: load/enable/terminal-count, width $clog2(TIMEOUT+1).

## Test plan
- Reset release, then ADD bundle `in_alu_out`=32'h0000_0005, `in_reg_wr`=1:
  - `s3_valid` 1 cycle later with `s3_data`=5 and `s3_reg_wr`=1.
  - `mem_busy` stays 0.
- Load from 16'h0040, ack after 3 wait cycles with `dmem_rdata`=16'hBEEF:
  - `mem_busy` is high for 4 cycles.
  - `s3_data`=32'h0000_BEEF, `s3_reg_wr`=1.
- Store 16'h1234 to 16'h0010 with zero-wait ack:
  - `dmem_we`=1, `dmem_wdata`=16'h1234.
  - `s3_reg_wr`=0.
  - A following `in_valid` is accepted one cycle after ack.
- No ack for `TIMEOUT`=15 cycles:
  - `dmem_req` drops after 15 cycles and `mem_err`=1.
  - `s3_valid` is emitted with `s3_reg_wr`=0.
- Misaligned load at 16'h0041, and a separate bundle with both `mem2r` and `memwr` set:
  - No `dmem_req` for either.
  - `mem_err`=1 for each.
- Sequence: `halt_sys` held 5 cycles during ACCESS, then `rst`=0 mid-access.
  - During halt, `dmem_addr` is unchanged and no `s3_valid`.
  - After the reset edge, all outputs are 0 and state=IDLE.
